// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit
//   Instruction-fetch stage for the 8-bit ALU datapath. It owns the program
//   counter, drives the ROM address bus and assembles two-byte instructions
//   (opcode byte, then immediate byte). Each instruction is handed to the
//   decode/ALU stage over a VALID/READY handshake.
//
// Ports
//   CLK, RST_N         rising-edge clock, asynchronous active-low reset
//   RUN                level, fetch enable (sampled only between instructions)
//   JMP_EN, JMP_ADDR   one-cycle jump request and target (highest priority)
//   ROM_ADDR           ROM address, always the PC register
//   ROM_DATA           combinational ROM read data for ROM_ADDR
//   INSTR_OP/IMM/ADDR  presented instruction and address of its opcode byte
//   OUT_VALID/READY    downstream handshake
//   BUSY               high whenever the fetch FSM is not idle
//   HALTED             only with FETCH_HALT_DET_EN: set once an 8'hFF opcode
//                      has been delivered, cleared by a jump or reset
//
// Optional feature macro: FETCH_HALT_DET_EN
module rom_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 8'h00
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  input  logic              JMP_EN,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_DATA,
  output logic [DATA_W-1:0] INSTR_OP,
  output logic [DATA_W-1:0] INSTR_IMM,
  output logic [ADDR_W-1:0] INSTR_ADDR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY
`ifdef FETCH_HALT_DET_EN
  ,
  output logic              HALTED
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_IMM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] op_reg;
  logic              xfer;
  logic              halt_hit;
  logic              halt_blk;

  assign xfer     = OUT_VALID & OUT_READY;
  assign ROM_ADDR = pc;
  assign BUSY     = (state != IDLE);

`ifdef FETCH_HALT_DET_EN
  logic halted;

  // The held opcode decides whether this transfer stops the fetcher.
  assign halt_hit = (INSTR_OP == {DATA_W{1'b1}});
  assign halt_blk = halted;
  assign HALTED   = halted;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      halted <= 1'b0;
    end else if (JMP_EN) begin
      halted <= 1'b0;
    end else if (state == HOLD && xfer && halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halt_blk = 1'b0;
`endif

  // Next-state logic; a jump overrides whatever the FSM was doing.
  always_comb begin
    state_nxt = state;
    if (JMP_EN) begin
      state_nxt = RUN ? FETCH_OP : IDLE;
    end else begin
      case (state)
        IDLE:      if (RUN && !halt_blk) state_nxt = FETCH_OP;
        FETCH_OP:  state_nxt = FETCH_IMM;
        FETCH_IMM: state_nxt = HOLD;
        HOLD:      if (xfer) state_nxt = (RUN && !halt_hit) ? FETCH_OP : IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC and valid flag; the PC wraps naturally at 2^ADDR_W.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc        <= RESET_ADDR;
      OUT_VALID <= 1'b0;
    end else if (JMP_EN) begin
      pc        <= JMP_ADDR;
      OUT_VALID <= 1'b0;
    end else begin
      if (state == FETCH_OP || state == FETCH_IMM) begin
        pc <= pc + ADDR_W'(1);
      end
      if (state == FETCH_IMM) begin
        OUT_VALID <= 1'b1;
      end else if (xfer) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

  // Instruction capture; a jump discards the bytes fetched in that cycle.
  // The opcode waits in op_reg so INSTR_* change together when the
  // immediate arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_reg     <= '0;
      INSTR_OP   <= '0;
      INSTR_IMM  <= '0;
      INSTR_ADDR <= '0;
    end else if (!JMP_EN) begin
      if (state == FETCH_OP) begin
        INSTR_ADDR <= pc;
        op_reg     <= ROM_DATA;
      end
      if (state == FETCH_IMM) begin
        INSTR_OP  <= op_reg;
        INSTR_IMM <= ROM_DATA;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit
//   Directed scenarios (first fetch, backpressure, jump, wrap-around, stop,
//   asynchronous reset, optional halt) followed by a randomized run checked
//   against an instruction-level reference model of the fetch stream.
module tb_rom_fetch_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RUN;
  logic       JMP_EN;
  logic [7:0] JMP_ADDR;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [7:0] INSTR_OP;
  logic [7:0] INSTR_IMM;
  logic [7:0] INSTR_ADDR;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
`ifdef FETCH_HALT_DET_EN
  logic       HALTED;
`endif

  logic [7:0] rom [256];
  assign ROM_DATA = rom[ROM_ADDR];

  rom_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_ADDR(8'h00)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .JMP_EN(JMP_EN), .JMP_ADDR(JMP_ADDR),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .INSTR_OP(INSTR_OP),
    .INSTR_IMM(INSTR_IMM), .INSTR_ADDR(INSTR_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .BUSY(BUSY)
`ifdef FETCH_HALT_DET_EN
    , .HALTED(HALTED)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // All outputs are registered; observe them mid-cycle, then drive inputs.
  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  // Reference model state for the random phase
  logic [7:0] ptr, p1, p2;
  logic       prev_jmp, prev_xfer, halted_m, xfer;
  int         delivered;

  initial begin
    RST_N = 1'b0; RUN = 1'b0; JMP_EN = 1'b0; JMP_ADDR = 8'h00; OUT_READY = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 254));
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h34;
    rom[8'h02] = 8'h56; rom[8'h03] = 8'h78;
    rom[8'h04] = 8'h9A; rom[8'h05] = 8'hBC;
    rom[8'h20] = 8'hA5; rom[8'h21] = 8'h5A;
    rom[8'hFF] = 8'h77;

    // Reset state
    #12;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_addr", ROM_ADDR, 8'h00);
    chk("rst_op", INSTR_OP, 0);
    chk("rst_imm", INSTR_IMM, 0);
    chk("rst_iaddr", INSTR_ADDR, 0);
    chk("rst_busy", BUSY, 0);

    // First fetch: 3 edges from RUN to OUT_VALID
    cyc(); RST_N = 1'b1; RUN = 1'b1;
    cyc(); chk("ff_addr0", ROM_ADDR, 8'h00); chk("ff_busy", BUSY, 1);
    cyc(); chk("ff_addr1", ROM_ADDR, 8'h01); chk("ff_vld0", OUT_VALID, 0);
    cyc(); chk("ff_addr2", ROM_ADDR, 8'h02); chk("ff_vld", OUT_VALID, 1);
    chk("ff_op", INSTR_OP, 8'h12); chk("ff_imm", INSTR_IMM, 8'h34);
    chk("ff_iaddr", INSTR_ADDR, 8'h00);
    cyc(); chk("ff_next_vld", OUT_VALID, 0); chk("ff_next_addr", ROM_ADDR, 8'h02);

    // Backpressure on the instruction at 02
    cyc(); chk("bp_addr3", ROM_ADDR, 8'h03);
    OUT_READY = 1'b0;
    cyc(); chk("bp_vld", OUT_VALID, 1); chk("bp_iaddr", INSTR_ADDR, 8'h02);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold_vld", OUT_VALID, 1);
      chk("bp_hold_op", INSTR_OP, 8'h56);
      chk("bp_hold_imm", INSTR_IMM, 8'h78);
      chk("bp_hold_romaddr", ROM_ADDR, 8'h04);
    end
    OUT_READY = 1'b1;
    cyc(); chk("bp_xfer_vld", OUT_VALID, 0); chk("bp_xfer_addr", ROM_ADDR, 8'h04);
    cyc();
    cyc(); chk("tp_vld", OUT_VALID, 1); chk("tp_iaddr", INSTR_ADDR, 8'h04);

    // Jump during FETCH_IMM of the instruction at 06
    cyc();
    cyc(); chk("jmp_pre_addr", ROM_ADDR, 8'h07);
    JMP_EN = 1'b1; JMP_ADDR = 8'h20;
    cyc(); JMP_EN = 1'b0;
    chk("jmp_vld", OUT_VALID, 0); chk("jmp_addr", ROM_ADDR, 8'h20);
    cyc(); chk("jmp_vld2", OUT_VALID, 0);
    cyc(); chk("jmp_ivld", OUT_VALID, 1);
    chk("jmp_op", INSTR_OP, 8'hA5); chk("jmp_imm", INSTR_IMM, 8'h5A);
    chk("jmp_iaddr", INSTR_ADDR, 8'h20);

    // Wrap-around: jump to FF coincident with the transfer of 20
    rom[8'h00] = 8'h01;
    JMP_EN = 1'b1; JMP_ADDR = 8'hFF;
    cyc(); JMP_EN = 1'b0;
    chk("wr_addr", ROM_ADDR, 8'hFF); chk("wr_vld0", OUT_VALID, 0);
    cyc(); chk("wr_addr0", ROM_ADDR, 8'h00);
    cyc(); chk("wr_vld", OUT_VALID, 1);
    chk("wr_op", INSTR_OP, 8'h77); chk("wr_imm", INSTR_IMM, 8'h01);
    chk("wr_iaddr", INSTR_ADDR, 8'hFF); chk("wr_next", ROM_ADDR, 8'h01);

    // Stop: RUN dropped during FETCH_OP still delivers that instruction
    cyc(); RUN = 1'b0;
    cyc();
    cyc(); chk("stop_vld", OUT_VALID, 1); chk("stop_iaddr", INSTR_ADDR, 8'h01);
    cyc(); chk("stop_busy", BUSY, 0); chk("stop_vld0", OUT_VALID, 0);
    cyc(); chk("stop_busy2", BUSY, 0); chk("stop_addr", ROM_ADDR, 8'h03);

    // Asynchronous reset in the middle of FETCH_IMM
    RUN = 1'b1;
    cyc();
    cyc(); chk("ar_pre_busy", BUSY, 1); chk("ar_pre_addr", ROM_ADDR, 8'h04);
    #2 RST_N = 1'b0;
    #1;
    chk("ar_vld", OUT_VALID, 0); chk("ar_addr", ROM_ADDR, 8'h00);
    chk("ar_busy", BUSY, 0);
    RUN = 1'b0;
    cyc(); RST_N = 1'b1;

`ifdef FETCH_HALT_DET_EN
    // Halt on an 8'hFF opcode at 04, released by a jump to 00
    rom[8'h00] = 8'h11; rom[8'h02] = 8'h22; rom[8'h04] = 8'hFF;
    OUT_READY = 1'b1; RUN = 1'b1;
    begin
      int k = 0;
      while (!(OUT_VALID && INSTR_ADDR == 8'h04) && k < 40) begin cyc(); k++; end
      chk("halt_seen", (k < 40), 1);
    end
    cyc(); chk("halt_flag", HALTED, 1); chk("halt_busy", BUSY, 0);
    cyc(); cyc(); chk("halt_stay", BUSY, 0);
    JMP_EN = 1'b1; JMP_ADDR = 8'h00;
    cyc(); JMP_EN = 1'b0;
    chk("halt_clr", HALTED, 0); chk("halt_resume", BUSY, 1);
    RUN = 1'b0;
    repeat (6) cyc();
    RST_N = 1'b0;
    cyc(); RST_N = 1'b1;
`endif

    // Randomized phase against an instruction-stream model
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    ptr = 8'h00; prev_jmp = 1'b0; prev_xfer = 1'b0; halted_m = 1'b0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (prev_jmp || prev_xfer) chk("rnd_vld_drop", OUT_VALID, 0);
      if (OUT_VALID) begin
        p1 = ptr + 8'd1;
        p2 = ptr + 8'd2;
        chk("rnd_iaddr", INSTR_ADDR, ptr);
        chk("rnd_op", INSTR_OP, rom[ptr]);
        chk("rnd_imm", INSTR_IMM, rom[p1]);
        chk("rnd_romaddr", ROM_ADDR, p2);
        chk("rnd_busy", BUSY, 1);
      end
`ifdef FETCH_HALT_DET_EN
      chk("rnd_halted", HALTED, halted_m);
      if (halted_m) chk("rnd_halt_idle", BUSY, 0);
`endif
      RUN       = ($urandom_range(0, 7) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      JMP_EN    = ($urandom_range(0, 19) == 0);
      JMP_ADDR  = 8'($urandom);
      xfer = OUT_VALID && OUT_READY;
      if (xfer) begin
        delivered++;
`ifdef FETCH_HALT_DET_EN
        if (rom[ptr] == 8'hFF) halted_m = 1'b1;
`endif
        ptr = ptr + 8'd2;
      end
      if (JMP_EN) begin
        ptr = JMP_ADDR;
        halted_m = 1'b0;
      end
      prev_jmp  = JMP_EN;
      prev_xfer = xfer;
    end
    JMP_EN = 1'b0;
    chk("rnd_progress", (delivered > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
